// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings and scoring defaults for the pong match blocks
package pong_pkg;

  typedef enum logic [1:0] {
    CONTANDO = 2'd0,
    ESPERA   = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int PONTOS_VITORIA_PADRAO = 5;

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - loadable post-point cooldown down-counter with freeze, clear and zero flag
module contador_espera #(
  parameter int ESPERA_CICLOS = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  input  logic carrega,
  output logic zero
);

  localparam int W = (ESPERA_CICLOS > 1) ? $clog2(ESPERA_CICLOS) : 1;

  logic [W-1:0] contagem;

  // Saturates at zero so an idle counter in CONTANDO reads as "cooldown over".
  always_ff @(posedge clk) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita) begin
      if (carrega) begin
        contagem <= W'(ESPERA_CICLOS - 1);
      end else if (contagem != '0) begin
        contagem <= contagem - 1'b1;
      end
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/placar_jogo.sv
// rtl/placar_jogo.sv - match scorekeeper feeding the game FSM; PONG_VANTAGEM_DOIS_EN selects win-by-two
module placar_jogo
  import pong_pkg::*;
#(
  parameter int PONTOS_VITORIA = PONTOS_VITORIA_PADRAO,
  parameter int LARGURA        = 4,
  parameter int ESPERA_CICLOS  = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               limpa,
  input  logic               pausa,
  input  logic               ponto_jogador,
  input  logic               ponto_cpu,
  output logic [LARGURA-1:0] pontos_jogador,
  output logic [LARGURA-1:0] pontos_cpu,
  output logic [LARGURA-1:0] final_jogador,
  output logic [LARGURA-1:0] final_cpu,
  output logic               ganhou,
  output logic               perdeu,
  output logic               ponto_marcado,
  output logic [1:0]         db_estado
);

`ifdef PONG_VANTAGEM_DOIS_EN
  localparam int MAXIMO = (1 << LARGURA) - 1;

  // A side pinned at the counter ceiling wins outright so the score never wraps.
  function automatic logic venceu(input int novo, input int outro);
    return ((novo >= PONTOS_VITORIA) && (novo - outro >= 2)) || (novo == MAXIMO);
  endfunction
`else
  function automatic logic venceu(input int novo, input int outro);
    return (novo == PONTOS_VITORIA) && (outro >= 0);
  endfunction
`endif

  estado_t estado, prox_estado;
  logic    so_jogador, so_cpu, aceita, vitoria, cooldown_zero, vencedor_jogador;

  // Simultaneous pulses cancel out: neither side scores.
  assign so_jogador = ponto_jogador & ~ponto_cpu;
  assign so_cpu     = ponto_cpu & ~ponto_jogador;
  assign aceita     = (estado == CONTANDO) && !limpa && !pausa && (so_jogador || so_cpu);
  assign vitoria    = so_jogador ? venceu(int'(pontos_jogador) + 1, int'(pontos_cpu))
                                 : venceu(int'(pontos_cpu) + 1, int'(pontos_jogador));

  contador_espera #(
    .ESPERA_CICLOS(ESPERA_CICLOS)
  ) u_espera (
    .clk     (clk),
    .reset   (reset),
    .limpa   (limpa),
    .habilita(!pausa),
    .carrega (aceita && !vitoria),
    .zero    (cooldown_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= CONTANDO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    if (limpa) begin
      prox_estado = CONTANDO;
    end else if (!pausa) begin
      case (estado)
        CONTANDO: if (aceita) prox_estado = vitoria ? FIM : ESPERA;
        ESPERA:   if (cooldown_zero) prox_estado = CONTANDO;
        FIM:      prox_estado = FIM;
        default:  prox_estado = CONTANDO;
      endcase
    end
  end

  always_comb begin
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    db_estado = estado;
    if (estado == FIM) begin
      ganhou = vencedor_jogador;
      perdeu = !vencedor_jogador;
    end
  end

  // final_* survive limpa so the FSM can keep showing the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pontos_jogador   <= '0;
      pontos_cpu       <= '0;
      final_jogador    <= '0;
      final_cpu        <= '0;
      ponto_marcado    <= 1'b0;
      vencedor_jogador <= 1'b0;
    end else if (limpa) begin
      pontos_jogador   <= '0;
      pontos_cpu       <= '0;
      ponto_marcado    <= 1'b0;
      vencedor_jogador <= 1'b0;
    end else begin
      ponto_marcado <= aceita;
      if (aceita) begin
        if (so_jogador) begin
          pontos_jogador <= pontos_jogador + 1'b1;
        end else begin
          pontos_cpu <= pontos_cpu + 1'b1;
        end
        if (vitoria) begin
          final_jogador    <= so_jogador ? pontos_jogador + 1'b1 : pontos_jogador;
          final_cpu        <= so_cpu ? pontos_cpu + 1'b1 : pontos_cpu;
          vencedor_jogador <= so_jogador;
        end
      end
    end
  end

endmodule

// File: tb/tb_placar_jogo.sv
// tb/tb_placar_jogo.sv - randomized and directed checks of placar_jogo against a behavioural score model
module tb_placar_jogo;

  localparam int PV   = 3;
  localparam int LARG = 4;
  localparam int ESP  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            limpa = 1'b0;
  logic            pausa = 1'b0;
  logic            ponto_jogador = 1'b0;
  logic            ponto_cpu = 1'b0;
  logic [LARG-1:0] pontos_jogador, pontos_cpu, final_jogador, final_cpu;
  logic            ganhou, perdeu, ponto_marcado;
  logic [1:0]      db_estado;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  int m_pj = 0, m_pc = 0, m_fj = 0, m_fc = 0, m_resta = 0, m_pm = 0;
  bit m_fim = 1'b0, m_venc_j = 1'b0;

  placar_jogo #(
    .PONTOS_VITORIA(PV),
    .LARGURA       (LARG),
    .ESPERA_CICLOS (ESP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .limpa         (limpa),
    .pausa         (pausa),
    .ponto_jogador (ponto_jogador),
    .ponto_cpu     (ponto_cpu),
    .pontos_jogador(pontos_jogador),
    .pontos_cpu    (pontos_cpu),
    .final_jogador (final_jogador),
    .final_cpu     (final_cpu),
    .ganhou        (ganhou),
    .perdeu        (perdeu),
    .ponto_marcado (ponto_marcado),
    .db_estado     (db_estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string nome, input int atual, input int esperado);
    n_total++;
    if (atual == esperado) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
  endtask

  function automatic bit vence(input int novo, input int outro);
`ifdef PONG_VANTAGEM_DOIS_EN
    return ((novo >= PV) && (novo - outro >= 2)) || (novo == (1 << LARG) - 1);
`else
    return novo == PV;
`endif
  endfunction

  // Reference: m_resta counts cooldown cycles still owed before points count again.
  always @(posedge clk) begin
    if (!reset) begin
      m_pj = 0; m_pc = 0; m_fj = 0; m_fc = 0; m_resta = 0; m_pm = 0;
      m_fim = 0; m_venc_j = 0;
    end else if (limpa) begin
      m_pj = 0; m_pc = 0; m_resta = 0; m_pm = 0; m_fim = 0; m_venc_j = 0;
    end else if (pausa) begin
      m_pm = 0;
    end else begin
      m_pm = 0;
      if (m_fim) begin
      end else if (m_resta > 0) begin
        m_resta = m_resta - 1;
      end else if (ponto_jogador != ponto_cpu) begin
        m_pm = 1;
        if (ponto_jogador) m_pj = m_pj + 1;
        else m_pc = m_pc + 1;
        if (ponto_jogador ? vence(m_pj, m_pc) : vence(m_pc, m_pj)) begin
          m_fim = 1; m_venc_j = ponto_jogador; m_fj = m_pj; m_fc = m_pc;
        end else begin
          m_resta = ESP;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pontos_jogador", int'(pontos_jogador), m_pj);
      check("pontos_cpu", int'(pontos_cpu), m_pc);
      check("final_jogador", int'(final_jogador), m_fj);
      check("final_cpu", int'(final_cpu), m_fc);
      check("ganhou", int'(ganhou), int'(m_fim && m_venc_j));
      check("perdeu", int'(perdeu), int'(m_fim && !m_venc_j));
      check("ponto_marcado", int'(ponto_marcado), m_pm);
      check("db_estado", int'(db_estado), m_fim ? 2 : (m_resta > 0 ? 1 : 0));
    end
  end

  task automatic ciclo(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulso(input bit jog, input bit cpu);
    ponto_jogador = jog;
    ponto_cpu = cpu;
    ciclo();
    ponto_jogador = 0;
    ponto_cpu = 0;
  endtask

  task automatic zera();
    limpa = 1;
    ciclo();
    limpa = 0;
  endtask

  int n_pm;

  initial begin
    ciclo(3);
    chk_en = 1;
    check("reset pontos_jogador", int'(pontos_jogador), 0);
    check("reset final_cpu", int'(final_cpu), 0);
    check("reset ganhou", int'(ganhou), 0);
    check("reset db_estado", int'(db_estado), 0);
    reset = 1;
    ciclo();

    for (int k = 1; k <= 3; k++) begin
      pulso(1, 0);
      check("t1 pontos_jogador", int'(pontos_jogador), k);
      check("t1 ponto_marcado", int'(ponto_marcado), 1);
      if (k == 3) begin
        check("t1 ganhou", int'(ganhou), 1);
        check("t1 final_jogador", int'(final_jogador), 3);
        check("t1 db_estado", int'(db_estado), 2);
      end
      ciclo(5);
    end

    zera();
    check("fim limpa pontos", int'(pontos_jogador), 0);
    check("fim limpa ganhou", int'(ganhou), 0);
    check("fim limpa final_jogador", int'(final_jogador), 3);
    check("fim limpa final_cpu", int'(final_cpu), 0);
    check("fim limpa db_estado", int'(db_estado), 0);

    n_pm = 0;
    pulso(1, 0);
    n_pm += int'(ponto_marcado);
    ciclo();
    n_pm += int'(ponto_marcado);
    pulso(0, 1);
    n_pm += int'(ponto_marcado);
    for (int i = 0; i < 3; i++) begin
      ciclo();
      n_pm += int'(ponto_marcado);
    end
    check("t2 pontos_cpu", int'(pontos_cpu), 0);
    check("t2 ponto_marcado count", n_pm, 1);
    check("t2 db_estado", int'(db_estado), 0);

    zera();
    pulso(1, 1);
    check("t3 pontos_jogador", int'(pontos_jogador), 0);
    check("t3 pontos_cpu", int'(pontos_cpu), 0);
    check("t3 ponto_marcado", int'(ponto_marcado), 0);
    check("t3 db_estado", int'(db_estado), 0);

    pulso(1, 0);
    ciclo();
    pausa = 1;
    for (int i = 0; i < 10; i++) begin
      ponto_cpu = (i == 3);
      ciclo();
    end
    ponto_cpu = 0;
    check("pausa db_estado", int'(db_estado), 1);
    check("pausa pontos_cpu", int'(pontos_cpu), 0);
    pausa = 0;
    ciclo(2);
    check("pausa retomada espera", int'(db_estado), 1);
    ciclo();
    check("pausa retomada contando", int'(db_estado), 0);

    pulso(1, 0);
    ciclo();
    reset = 0;
    ciclo();
    check("reset espera pontos", int'(pontos_jogador), 0);
    check("reset espera final", int'(final_jogador), 0);
    check("reset espera db_estado", int'(db_estado), 0);
    reset = 1;
    ciclo();

`ifdef PONG_VANTAGEM_DOIS_EN
    for (int i = 0; i < 8; i++) begin
      pulso((i % 2 == 0) || (i == 7), (i % 2 == 1) && (i != 7));
      if (i == 6) begin
        check("deuce 4-3 ganhou", int'(ganhou), 0);
        check("deuce 4-3 pontos", int'(pontos_jogador), 4);
      end
      if (i == 7) begin
        check("deuce 5-3 ganhou", int'(ganhou), 1);
        check("deuce 5-3 final", int'(final_jogador), 5);
      end
      ciclo(5);
    end
    zera();
`endif

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      limpa = ($urandom_range(0, 79) == 0);
      pausa = ($urandom_range(0, 11) == 0);
      ponto_jogador = ($urandom_range(0, 5) == 0);
      ponto_cpu = ($urandom_range(0, 6) == 0);
      ciclo();
    end
    reset = 1; limpa = 0; pausa = 0; ponto_jogador = 0; ponto_cpu = 0;
    ciclo(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
